conv_encoder_213: RTL

CONV_ENCODER_213 -- requirements
Module: conv_encoder_213

---
 rtl/conv_encoder_213_pkg.sv | 39 +++
 rtl/enc_213_symbol.sv | 21 ++
 rtl/conv_encoder_213.sv | 126 ++++++++++++
 3 files changed

// File: rtl/conv_encoder_213_pkg.sv
// conv_encoder_213_pkg
//   Shared constants and helpers for the (2,1,3) feed-forward convolutional
//   code. The same generator polynomials and the parity helper are used by the
//   encoder and by any reference model of the decoder's branch metrics.
//   Contents:
//     N, K, M       symbol width, information width, memory order
//     G1, G2        generator taps, MSB = u coefficient, LSB = D^M coefficient
//     enc_state_t   encoder FSM states
//     gen_parity()  modulo-2 inner product of a generator with {u, sr}
package conv_encoder_213_pkg;

  localparam int N = 2;  // code symbol width
  localparam int K = 1;  // information bits per symbol
  localparam int M = 3;  // memory order (shift register length)

  // g1 = 1 + D^2 + D^3, g2 = 1 + D + D^2 + D^3
  localparam logic [M:0] G1 = 4'b1011;
  localparam logic [M:0] G2 = 4'b1111;

  // A frame is terminated by M zero-input symbols.
  localparam int TAIL_LEN = M;

  typedef enum logic {
    ST_DATA = 1'b0,
    ST_TAIL = 1'b1
  } enc_state_t;

  // taps[M] is the current input u, taps[M-1-i] is sr[i] (delay D^(i+1)), so
  // generator bit j lines up with the D^(M-j) coefficient.
  function automatic logic gen_parity(input logic [M:0]   g,
                                      input logic         u,
                                      input logic [M-1:0] sr);
    logic [M:0] taps;
    taps[M] = u;
    for (int i = 0; i < M; i++) taps[M-1-i] = sr[i];
    return ^(g & taps);
  endfunction

endpackage

// File: rtl/enc_213_symbol.sv
// enc_213_symbol
//   Purely combinational symbol generator for the (2,1,3) code.
//   Ports:
//     u    in   current information bit
//     sr   in   encoder memory, sr[0] = D^1 ... sr[M-1] = D^M
//     sym  out  code symbol, sym[1] = g1 output, sym[0] = g2 output
module enc_213_symbol
  import conv_encoder_213_pkg::*;
(
  input  logic         u,
  input  logic [M-1:0] sr,
  output logic [N-1:0] sym
);

  always_comb begin
    sym    = '0;
    sym[1] = gen_parity(G1, u, sr);
    sym[0] = gen_parity(G2, u, sr);
  end

endmodule

// File: rtl/conv_encoder_213.sv
// conv_encoder_213
//   Framed (2,1,3) convolutional encoder with valid/ready handshakes on both
//   sides. Each frame is FRAME_LEN information bits followed by M zero-input
//   tail symbols that drive the trellis back to the all-zero state.
//   Parameters:
//     FRAME_LEN  information bits per frame, 1..1023
//   Ports:
//     clock     in   system clock, rising edge
//     reset     in   synchronous active-high reset
//     Dx        in   information bit
//     dx_valid  in   Dx is valid
//     dx_ready  out  Dx accepted this cycle when dx_valid is also high
//     Tx        out  code symbol {g1, g2}
//     oe        out  Tx holds a valid symbol
//     tx_ready  in   downstream consumes Tx when oe is high
//     tx_last   out  Tx is the final tail symbol of the frame (with oe)
module conv_encoder_213
  import conv_encoder_213_pkg::*;
#(
  parameter int FRAME_LEN = 20
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [K-1:0] Dx,
  input  logic         dx_valid,
  output logic         dx_ready,
  output logic [N-1:0] Tx,
  output logic         oe,
  input  logic         tx_ready,
  output logic         tx_last
);

  localparam int               CW        = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0]    CNT_LAST  = CW'(FRAME_LEN - 1);
  localparam logic [1:0]       TAIL_LAST = 2'(TAIL_LEN - 1);

  enc_state_t    state, state_nxt;
  logic [M-1:0]  sr, sr_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    tail_cnt, tail_nxt;
  logic [N-1:0]  tx_nxt;
  logic          oe_nxt, last_nxt;

  logic          free;
  logic          load;
  logic          u;
  logic [N-1:0]  sym;

  // The output register can take a new symbol if it is empty or is being
  // drained this cycle; this is what gives one symbol per cycle under flow.
  assign free = !oe || tx_ready;

  // Ready depends only on state/oe/tx_ready, never on dx_valid.
  assign dx_ready = (state == ST_DATA) && free && !reset;

  // TAIL loads a flush symbol every free cycle regardless of input.
  assign load = free && ((state == ST_TAIL) || dx_valid);

  assign u = (state == ST_TAIL) ? 1'b0 : Dx[0];

  enc_213_symbol u_sym (
    .u   (u),
    .sr  (sr),
    .sym (sym)
  );

  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    cnt_nxt   = cnt;
    tail_nxt  = tail_cnt;
    tx_nxt    = Tx;
    oe_nxt    = oe;
    last_nxt  = tx_last;

    if (load) begin
      tx_nxt   = sym;
      oe_nxt   = 1'b1;
      last_nxt = 1'b0;
      sr_nxt   = {sr[M-2:0], u};
      if (state == ST_DATA) begin
        if (cnt == CNT_LAST) begin
          state_nxt = ST_TAIL;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end else begin
        if (tail_cnt == TAIL_LAST) begin
          // Three zero shifts already clear sr; forcing it makes termination
          // explicit and independent of the shift path.
          last_nxt  = 1'b1;
          state_nxt = ST_DATA;
          tail_nxt  = '0;
          sr_nxt    = '0;
        end else begin
          tail_nxt = tail_cnt + 1'b1;
        end
      end
    end else if (oe && tx_ready) begin
      oe_nxt   = 1'b0;
      last_nxt = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_DATA;
      sr       <= '0;
      cnt      <= '0;
      tail_cnt <= '0;
      Tx       <= '0;
      oe       <= 1'b0;
      tx_last  <= 1'b0;
    end else begin
      state    <= state_nxt;
      sr       <= sr_nxt;
      cnt      <= cnt_nxt;
      tail_cnt <= tail_nxt;
      Tx       <= tx_nxt;
      oe       <= oe_nxt;
      tx_last  <= last_nxt;
    end
  end

endmodule
